// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
// Pipeline hazard controller: produces write enables and bubble (flush)
// controls for a five-stage pipeline from memory-busy, load-use, taken-branch
// and multi-cycle mul/div events.
//
// Priority when no memory is busy: mul/div > taken branch > load-use.
// A busy instruction or data memory freezes the whole pipeline and this
// controller's own state.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   IM_stall, DM_stall  instruction / data memory busy
//   ID_RegAddr1/2       source registers of the instruction in ID
//   EX_RdAddr           destination register of the instruction in EX
//   EX_MemRead          EX holds a load
//   EX_BranchTaken      EX resolved a taken branch
//   EX_MulDiv           EX holds a multi-cycle mul/div op
//   *_Write             pipeline register write enables
//   *_Flush             bubble insertion into the named pipeline register
//   MulDiv_Busy         high in every mul/div stall cycle
//   MulDiv_Done         one-cycle pulse in the first advance after a stall
//   Stall_Cnt           (only with HAZARD_PERF_CNT_EN) saturating count of
//                       non-reset cycles with PC_Write=0
//
// Parameter MULDIV_LAT (2..15): number of stall cycles for a mul/div op.
// Optional feature macro: HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
  parameter int MULDIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IM_stall,
  input  logic        DM_stall,
  input  logic [4:0]  ID_RegAddr1,
  input  logic [4:0]  ID_RegAddr2,
  input  logic [4:0]  EX_RdAddr,
  input  logic        EX_MemRead,
  input  logic        EX_BranchTaken,
  input  logic        EX_MulDiv,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IDEX_Write,
  output logic        EXMEM_Write,
  output logic        MEMWB_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        EXMEM_Flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] Stall_Cnt,
`endif
  output logic        MulDiv_Busy,
  output logic        MulDiv_Done
);

  typedef enum logic {S_RUN, S_MULDIV} stateT;

  stateT      stateReg, stateNext;
  logic [3:0] cntReg, cntNext;
  logic       mdDoneReg, mdDoneNext;

  logic memBusy;
  logic loadUse;

  assign memBusy = IM_stall | DM_stall;
  assign loadUse = EX_MemRead && (EX_RdAddr != 5'd0) &&
                   ((EX_RdAddr == ID_RegAddr1) || (EX_RdAddr == ID_RegAddr2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg  <= S_RUN;
      cntReg    <= 4'd0;
      mdDoneReg <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      cntReg    <= cntNext;
      mdDoneReg <= mdDoneNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    cntNext     = cntReg;
    mdDoneNext  = mdDoneReg;
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Write  = 1'b1;
    EXMEM_Write = 1'b1;
    MEMWB_Write = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    MulDiv_Busy = 1'b0;
    MulDiv_Done = 1'b0;

    if (rst || memBusy) begin
      // Everything frozen; registered state holds (or is being reset).
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      EXMEM_Write = 1'b0;
      MEMWB_Write = 1'b0;
    end else if (stateReg == S_MULDIV) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      EXMEM_Flush = 1'b1;
      MulDiv_Busy = 1'b1;
      if (cntReg == 4'd1) begin
        stateNext  = S_RUN;
        cntNext    = 4'd0;
        mdDoneNext = 1'b1;
      end else begin
        cntNext = cntReg - 4'd1;
      end
    end else if (mdDoneReg) begin
      // The finished op is still sitting in EX with EX_MulDiv high; let it
      // advance once instead of re-triggering.
      MulDiv_Done = 1'b1;
      mdDoneNext  = 1'b0;
    end else if (EX_MulDiv) begin
      // Entry cycle counts as the first of the MULDIV_LAT stall cycles.
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      EXMEM_Flush = 1'b1;
      MulDiv_Busy = 1'b1;
      cntNext     = 4'(MULDIV_LAT - 1);
      stateNext   = S_MULDIV;
    end else if (EX_BranchTaken) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (loadUse) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCntReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCntReg <= 32'd0;
    end else if (!PC_Write && (stallCntReg != 32'hFFFF_FFFF)) begin
      stallCntReg <= stallCntReg + 32'd1;
    end
  end

  assign Stall_Cnt = stallCntReg;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

  logic       clk;
  logic       rst;
  logic       IM_stall, DM_stall;
  logic [4:0] ID_RegAddr1, ID_RegAddr2, EX_RdAddr;
  logic       EX_MemRead, EX_BranchTaken, EX_MulDiv;
  logic       PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write;
  logic       IFID_Flush, IDEX_Flush, EXMEM_Flush;
  logic       MulDiv_Busy, MulDiv_Done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] Stall_Cnt;
`endif

  hazard_ctrl_unit #(.MULDIV_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .IM_stall(IM_stall), .DM_stall(DM_stall),
    .ID_RegAddr1(ID_RegAddr1), .ID_RegAddr2(ID_RegAddr2),
    .EX_RdAddr(EX_RdAddr), .EX_MemRead(EX_MemRead),
    .EX_BranchTaken(EX_BranchTaken), .EX_MulDiv(EX_MulDiv),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
    .EXMEM_Write(EXMEM_Write), .MEMWB_Write(MEMWB_Write),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
`ifdef HAZARD_PERF_CNT_EN
    .Stall_Cnt(Stall_Cnt),
`endif
    .MulDiv_Busy(MulDiv_Busy), .MulDiv_Done(MulDiv_Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC,IFID,IDEX,EXMEM,MEMWB}_Write, {IFID,IDEX,EXMEM}_Flush, Busy, Done
  logic [9:0] outVec;
  assign outVec = {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
                   IFID_Flush, IDEX_Flush, EXMEM_Flush, MulDiv_Busy, MulDiv_Done};

  localparam logic [9:0] O_ZERO = 10'b00000_000_00;
  localparam logic [9:0] O_DEF  = 10'b11111_000_00;
  localparam logic [9:0] O_LU   = 10'b00111_010_00;
  localparam logic [9:0] O_BR   = 10'b11111_110_00;
  localparam logic [9:0] O_MD   = 10'b00011_001_10;
  localparam logic [9:0] O_DONE = 10'b11111_000_01;

  typedef struct packed {
    logic       r;
    logic       im, dm;
    logic [4:0] a1, a2, rd;
    logic       mr, br, md;
  } stimT;

  logic [9:0]  sbq[$];
  logic [31:0] cntq[$];
  logic [9:0]  expV;
  int checks = 0;
  int failures = 0;

  function automatic stimT mk(logic r, logic im, logic dm, logic [4:0] a1,
                              logic [4:0] a2, logic [4:0] rd, logic mr,
                              logic br, logic md);
    stimT s;
    s = '{r, im, dm, a1, a2, rd, mr, br, md};
    return s;
  endfunction

  // Drive one cycle's inputs and queue the outputs they must produce.
  task automatic drive(input stimT s, input logic [9:0] e);
    rst = s.r; IM_stall = s.im; DM_stall = s.dm;
    ID_RegAddr1 = s.a1; ID_RegAddr2 = s.a2; EX_RdAddr = s.rd;
    EX_MemRead = s.mr; EX_BranchTaken = s.br; EX_MulDiv = s.md;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    stimT s[3]; logic [9:0] e[3];
    s[0] = mk(1,0,0,1,2,1,1,1,1); e[0] = O_ZERO;
    s[1] = mk(1,0,0,0,0,0,0,0,0); e[1] = O_ZERO;
    s[2] = mk(0,0,0,0,0,0,0,0,0); e[2] = O_DEF;
    for (int i = 0; i < 3; i++) begin
      drive(s[i], e[i]);
      @(negedge clk);
      expV = sbq.pop_front();
      checks++;
      if (outVec !== expV) begin
        failures++;
        $display("FAIL reset[%0d] got=%b exp=%b", i, outVec, expV);
      end else $display("ok reset[%0d] out=%b", i, outVec);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stimT s[6]; logic [9:0] e[6];
    s[0] = mk(0,0,0,3,5,5,1,0,0); e[0] = O_LU;
    s[1] = mk(0,0,0,3,6,5,0,0,0); e[1] = O_DEF;
    s[2] = mk(0,0,0,0,0,0,1,0,0); e[2] = O_DEF;   // x0 never stalls
    s[3] = mk(0,0,0,7,1,7,1,0,0); e[3] = O_LU;    // match on RegAddr1
    s[4] = mk(0,0,0,7,7,7,0,0,0); e[4] = O_DEF;   // not a load
    s[5] = mk(0,0,0,4,6,5,1,0,0); e[5] = O_DEF;   // no match
    for (int i = 0; i < 6; i++) begin
      drive(s[i], e[i]);
      @(negedge clk);
      expV = sbq.pop_front();
      checks++;
      if (outVec !== expV) begin
        failures++;
        $display("FAIL load_use[%0d] got=%b exp=%b", i, outVec, expV);
      end else $display("ok load_use[%0d] out=%b", i, outVec);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    stimT s[4]; logic [9:0] e[4];
    s[0] = mk(0,0,0,5,5,5,1,1,0); e[0] = O_BR;    // branch beats load-use
    s[1] = mk(0,0,0,0,0,0,0,1,0); e[1] = O_BR;
    s[2] = mk(0,1,0,5,5,5,1,1,0); e[2] = O_ZERO;  // memory busy beats all
    s[3] = mk(0,0,0,0,0,0,0,0,0); e[3] = O_DEF;
    for (int i = 0; i < 4; i++) begin
      drive(s[i], e[i]);
      @(negedge clk);
      expV = sbq.pop_front();
      checks++;
      if (outVec !== expV) begin
        failures++;
        $display("FAIL priority[%0d] got=%b exp=%b", i, outVec, expV);
      end else $display("ok priority[%0d] out=%b", i, outVec);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_muldiv();
    stimT s[7]; logic [9:0] e[7];
    for (int i = 0; i < 4; i++) begin
      s[i] = mk(0,0,0,0,0,0,0,(i == 2),1); e[i] = O_MD;  // branch ignored
    end
    s[4] = mk(0,0,0,0,0,0,0,0,1); e[4] = O_DONE;  // EX_MulDiv still high
    s[5] = mk(0,0,0,0,0,0,0,0,0); e[5] = O_DEF;
    s[6] = mk(0,0,0,0,0,0,0,0,0); e[6] = O_DEF;
    for (int i = 0; i < 7; i++) begin
      drive(s[i], e[i]);
      @(negedge clk);
      expV = sbq.pop_front();
      checks++;
      if (outVec !== expV) begin
        failures++;
        $display("FAIL muldiv[t+%0d] got=%b exp=%b", i, outVec, expV);
      end else $display("ok muldiv[t+%0d] out=%b", i, outVec);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_freeze();
    stimT s[9]; logic [9:0] e[9];
    s[0] = mk(0,0,0,0,0,0,0,0,1); e[0] = O_MD;
    for (int i = 1; i < 4; i++) begin
      s[i] = mk(0,0,1,0,0,0,0,0,1); e[i] = O_ZERO;
    end
    for (int i = 4; i < 7; i++) begin
      s[i] = mk(0,0,0,0,0,0,0,0,1); e[i] = O_MD;
    end
    s[7] = mk(0,0,0,0,0,0,0,0,1); e[7] = O_DONE;
    s[8] = mk(0,0,0,0,0,0,0,0,0); e[8] = O_DEF;
    for (int i = 0; i < 9; i++) begin
      drive(s[i], e[i]);
      @(negedge clk);
      expV = sbq.pop_front();
      checks++;
      if (outVec !== expV) begin
        failures++;
        $display("FAIL freeze[t+%0d] got=%b exp=%b", i, outVec, expV);
      end else $display("ok freeze[t+%0d] out=%b", i, outVec);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midop();
    stimT s[7]; logic [9:0] e[7];
    s[0] = mk(0,0,0,0,0,0,0,0,1); e[0] = O_MD;
    s[1] = mk(0,0,0,0,0,0,0,0,1); e[1] = O_MD;
    s[2] = mk(1,0,0,0,0,0,0,0,1); e[2] = O_ZERO;
    for (int i = 3; i < 7; i++) begin
      s[i] = mk(0,0,0,0,0,0,0,0,0); e[i] = O_DEF;  // no stall, no Done
    end
    for (int i = 0; i < 7; i++) begin
      drive(s[i], e[i]);
      @(negedge clk);
      expV = sbq.pop_front();
      checks++;
      if (outVec !== expV) begin
        failures++;
        $display("FAIL reset_midop[t+%0d] got=%b exp=%b", i, outVec, expV);
      end else $display("ok reset_midop[t+%0d] out=%b", i, outVec);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stimT s[11]; logic [9:0] e[11];
    for (int i = 0; i < 10; i++) begin
      s[i] = mk(0,0,0,0,0,0,0,0,1);
      e[i] = (i == 4 || i == 9) ? O_DONE : O_MD;
    end
    s[10] = mk(0,0,0,0,0,0,0,0,0); e[10] = O_DEF;
    for (int i = 0; i < 11; i++) begin
      drive(s[i], e[i]);
      @(negedge clk);
      expV = sbq.pop_front();
      checks++;
      if (outVec !== expV) begin
        failures++;
        $display("FAIL back_to_back[%0d] got=%b exp=%b", i, outVec, expV);
      end else $display("ok back_to_back[%0d] out=%b", i, outVec);
      @(posedge clk); #1;
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    stimT s[9]; logic [9:0] e[9];
    logic [31:0] expC;
    s[0] = mk(1,0,0,0,0,0,0,0,0); e[0] = O_ZERO;
    s[1] = mk(0,0,0,3,5,5,1,0,0); e[1] = O_LU;
    s[2] = mk(0,0,0,0,0,0,0,0,0); e[2] = O_DEF;
    for (int i = 3; i < 7; i++) begin
      s[i] = mk(0,0,0,0,0,0,0,0,1); e[i] = O_MD;
    end
    s[7] = mk(0,0,0,0,0,0,0,0,1); e[7] = O_DONE;
    s[8] = mk(0,0,0,0,0,0,0,0,0); e[8] = O_DEF;
    for (int i = 0; i < 9; i++) begin
      drive(s[i], e[i]);
      @(negedge clk);
      expV = sbq.pop_front();
      checks++;
      if (outVec !== expV) begin
        failures++;
        $display("FAIL perf_seq[%0d] got=%b exp=%b", i, outVec, expV);
      end
      @(posedge clk); #1;
    end
    cntq.push_back(32'd5);
    @(negedge clk);
    expC = cntq.pop_front();
    checks++;
    if (Stall_Cnt !== expC) begin
      failures++;
      $display("FAIL stall_cnt got=%0d exp=%0d", Stall_Cnt, expC);
    end else $display("ok stall_cnt=%0d", Stall_Cnt);
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst = 1'b1; IM_stall = 1'b0; DM_stall = 1'b0;
    ID_RegAddr1 = '0; ID_RegAddr2 = '0; EX_RdAddr = '0;
    EX_MemRead = 1'b0; EX_BranchTaken = 1'b0; EX_MulDiv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_load_use();
    test_priority();
    test_muldiv();
    test_freeze();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameter MULDIV_LAT, default 4, the number of stall cycles for a multi-cycle ALU op; legal range is 2..15.
REQ-002 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 IM_stall, DM_stall  in  1 each  instruction / data memory busy.
REQ-005 ID_RegAddr1, ID_RegAddr2  in  5 each  source registers of the instruction in ID.
REQ-006 EX_RdAddr  in  5  destination register of the instruction in EX.
REQ-007 EX_MemRead, EX_BranchTaken, EX_MulDiv  in  1 each  EX-stage load / resolved taken branch / mul-div op.
REQ-008 PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write  out  1 each  pipeline register write enables.
REQ-009 IFID_Flush, IDEX_Flush, EXMEM_Flush  out  1 each  bubble insertion into the named register.
REQ-010 MulDiv_Busy  out  1  high in every mul-div stall cycle.
REQ-011 MulDiv_Done  out  1  one-cycle pulse in the first advance cycle after a mul-div stall.

Function
REQ-012 The FSM SHALL have exactly two states, S_RUN and S_MULDIV, plus a 4-bit down-counter cnt and a 1-bit md_done flag.
REQ-013 mem_busy = IM_stall | DM_stall.
REQ-014 When mem_busy=1 in any state:
  - all Write outputs SHALL be 0;
  - all Flush outputs, MulDiv_Busy and MulDiv_Done SHALL be 0;
  - state, cnt and md_done SHALL hold.
REQ-015 Default (no event): all Write outputs 1, all Flush outputs 0.
REQ-016 Event priority when mem_busy=0: mul-div (S_MULDIV, or S_RUN with a new EX_MulDiv) > EX_BranchTaken > load-use.
REQ-017 Mul-div entry: in S_RUN with EX_MulDiv=1 and md_done=0, the block SHALL:
  - drive PC_Write=IFID_Write=IDEX_Write=0, EXMEM_Flush=1, MulDiv_Busy=1;
  - load cnt with MULDIV_LAT-1;
  - enter S_MULDIV.
REQ-018 In S_MULDIV, the outputs SHALL equal those of REQ-017, and cnt SHALL decrement each cycle.
REQ-019 When cnt==1 in S_MULDIV, the FSM SHALL enter S_RUN and set md_done. Total stall is exactly MULDIV_LAT cycles.
REQ-020 In S_RUN with md_done=1, the block SHALL:
  - drive MulDiv_Done=1 with the default outputs;
  - ignore EX_MulDiv;
  - clear md_done.
REQ-021 Branch: EX_BranchTaken=1 SHALL drive IFID_Flush=IDEX_Flush=1, with PC_Write=1 and the other outputs at default.
REQ-022 Load-use: condition is EX_MemRead=1, EX_RdAddr!=0, and EX_RdAddr equal to ID_RegAddr1 or ID_RegAddr2. The block SHALL then drive PC_Write=IFID_Write=0 and IDEX_Flush=1, with the other outputs at default.
REQ-023 Load-use with EX_RdAddr==0 SHALL NOT stall.
REQ-024 Outputs SHALL be combinational from state, cnt, md_done and the inputs; there SHALL be no combinational path from Flush outputs to Write outputs.

Reset
REQ-025 While rst=1, the block SHALL:
  - drive all Write, Flush, MulDiv_Busy and MulDiv_Done outputs to 0;
  - hold state=S_RUN, cnt=0, md_done=0.
REQ-026 rst asserted mid-mul-div SHALL abort the operation immediately, with no MulDiv_Done pulse after release.

Configuration
REQ-027 Macro HAZARD_PERF_CNT_EN, when defined, SHALL add output Stall_Cnt (32 bits). Stall_Cnt SHALL:
  - reset to 0;
  - increment in every non-reset cycle with PC_Write=0;
  - saturate at 0xFFFFFFFF.
REQ-028 Without HAZARD_PERF_CNT_EN, the Stall_Cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Load-use: EX_MemRead=1, EX_RdAddr=5, ID_RegAddr2=5 -> PC_Write=0, IFID_Write=0, IDEX_Flush=1 for one cycle. Repeat with EX_RdAddr=0 -> no stall.
REQ-030 Mul-div (MULDIV_LAT=4): EX_MulDiv=1 at cycle t -> MulDiv_Busy=1 and PC_Write=0 at t..t+3; MulDiv_Done=1 and PC_Write=1 at t+4 with EX_MulDiv still 1; no retrigger.
REQ-031 Freeze during mul-div: DM_stall=1 for 3 cycles starting t+1 -> all Write=0 and Flush=0 in those cycles; stall resumes after; MulDiv_Done at t+7.
REQ-032 Priority: EX_BranchTaken=1 together with a load-use match -> IFID_Flush=IDEX_Flush=1, PC_Write=1.
REQ-033 Reset mid-op: rst pulse at t+2 of a mul-div -> outputs 0 during rst; default outputs after release; no MulDiv_Done pulse.
REQ-034 With HAZARD_PERF_CNT_EN defined: the REQ-029 stall plus the REQ-030 sequence -> Stall_Cnt=5.
